// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : arbitration mode (open round-robin or debug-locked)
//   owner_t     : which port owns the memory / won the last arbitration
//   lock_cnt_w  : width of the lock counter for a given LOCK_MAX
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  function automatic int lock_cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_lock_timer.sv
// Debug lock timer: counts the dbg grants of a locked burst (the entering
// grant counts as the first) and flags expiry when the burst reaches
// LOCK_MAX. On expiry a one-cycle cpu_prio flag is raised for the next
// arbitration cycle.
//   clk, rst  : clock, synchronous active-low reset
//   start     : dbg granted with lock while arbitrating (counter loads 1)
//   run       : arbiter is in the locked state this cycle
//   unlock    : dbg dropped its lock while locked (counter clears)
//   expire    : this cycle's count reaches LOCK_MAX (combinational)
//   cpu_prio  : registered one-cycle CPU priority after a forced release
module arb_lock_timer
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic unlock,
  output logic expire,
  output logic cpu_prio
);

  localparam int CNT_W = lock_cnt_w(LOCK_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             prio_q, prio_d;

  always_comb begin
    cnt_inc = '0;
    if (start) begin
      cnt_inc = CNT_W'(1);
    end else if (run) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
    expire = (start || run) && (cnt_inc == CNT_W'(LOCK_MAX));
    // The counter only lives while a lock is held; any exit clears it.
    cnt_d  = (expire || unlock || !(start || run)) ? '0 : cnt_inc;
    prio_d = expire;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      prio_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prio_q <= prio_d;
    end
  end

  assign cpu_prio = prio_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory between the CPU
// data port and a debug/loader port. One access per cycle, round-robin on
// contention, optional bounded debug lock for bursts. Grants and memory
// drive are combinational; read data returns registered one cycle later.
//   clk, rst                         : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata            : CPU access request
//   cpu_gnt, cpu_stall               : CPU access performed / stalled
//   cpu_rvalid, cpu_rdata            : CPU read return (one cycle after grant)
//   dbg_req/we/addr/wdata, dbg_lock  : debug access request and lock
//   dbg_gnt, dbg_rvalid, dbg_rdata   : debug grant and read return
//   mem_we, mem_addr, mem_wdata      : drive to the data memory
//   mem_rdata                        : combinational read data from memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_q, state_d;
  owner_t        last_q, last_d;
  logic          cpu_prio, expire;
  logic          lock_start, lock_run, lock_drop;
  logic          cpu_rd, dbg_rd;
  logic          cpu_vld_p1, dbg_vld_p1;
  logic [DW-1:0] cpu_rdata_p1, dbg_rdata_p1;
  logic [DW-1:0] cpu_rdata_d, dbg_rdata_d;

  // Stage 0: grant decision and memory drive
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    // No access is performed while reset is held.
    if (rst) begin
      if (state_q == LOCKED) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (cpu_prio || last_q == OWN_DBG) begin
          cpu_gnt = 1'b1;
        end else begin
          dbg_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign lock_start = (state_q == ARB) & dbg_gnt & dbg_lock;
  assign lock_run   = (state_q == LOCKED);
  assign lock_drop  = lock_run & ~dbg_lock;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  arb_lock_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (lock_start),
    .run     (lock_run),
    .unlock  (lock_drop),
    .expire  (expire),
    .cpu_prio(cpu_prio)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      // An entering grant that already hits LOCK_MAX never enters LOCKED.
      ARB:     if (lock_start && !expire) state_d = LOCKED;
      LOCKED:  if (expire || !dbg_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
    last_d = last_q;
    if (cpu_gnt) begin
      last_d = OWN_CPU;
    end else if (dbg_gnt || expire) begin
      last_d = OWN_DBG;
    end
  end

  always_comb begin
    cpu_rd      = cpu_gnt & ~cpu_we;
    dbg_rd      = dbg_gnt & ~dbg_we;
    cpu_rdata_d = cpu_rd ? mem_rdata : cpu_rdata_p1;
    dbg_rdata_d = dbg_rd ? mem_rdata : dbg_rdata_p1;
  end

  // Stage 1: read return registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB;
      last_q       <= OWN_DBG;
      cpu_vld_p1   <= 1'b0;
      dbg_vld_p1   <= 1'b0;
      cpu_rdata_p1 <= '0;
      dbg_rdata_p1 <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cpu_vld_p1   <= cpu_rd;
      dbg_vld_p1   <= dbg_rd;
      cpu_rdata_p1 <= cpu_rdata_d;
      dbg_rdata_p1 <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_vld_p1;
  assign cpu_rdata  = cpu_rdata_p1;
  assign dbg_rvalid = dbg_vld_p1;
  assign dbg_rdata  = dbg_rdata_p1;

endmodule
